// File: rtl/pc_seq_if.sv
// Bundles the control-unit, ALU-flag and instruction-address signals
// of the program-counter sequencer into one interface.
interface pc_seq_if #(
    parameter int WIDTH = 32
);
    logic              pc_write;
    logic [2:0]        pc_sel;
    logic [1:0]        br_cond;
    logic              igual;
    logic              maior;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic [WIDTH-1:0]  reg_target;
    logic              exc_req;
    logic [1:0]        exc_code;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  epc;
    logic              exc_busy;
    logic              exc_ack;

    // Control side: drives the request/select inputs, observes the PC state
    modport master (
        output pc_write, pc_sel, br_cond, igual, maior, imm, target,
               reg_target, exc_req, exc_code,
        input  pc, pc_plus4, epc, exc_busy, exc_ack
    );

    // Sequencer side
    modport slave (
        input  pc_write, pc_sel, br_cond, igual, maior, imm, target,
               reg_target, exc_req, exc_code,
        output pc, pc_plus4, epc, exc_busy, exc_ack
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer for the multicycle MIPS datapath: holds the PC
// and EPC, computes all next-PC modes and runs the exception entry sequence
// (save EPC, then load the vector) including misaligned jr detection.
module pc_seq #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_BASE     = 'h0000_00F0
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_VEC  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_JUMP   = 3'b010;
    localparam logic [2:0] SEL_JR     = 3'b011;
    localparam logic [2:0] SEL_RTE    = 3'b100;
    localparam logic [1:0] CODE_ALIGN = 2'd3;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic [1:0]       code_reg, code_next;
    logic             ack_reg, ack_next;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] vector;
    logic [WIDTH-1:0] target_pc;
    logic             br_taken;
    logic             jr_misaligned;

    assign pc_plus4 = pc_reg + {{(WIDTH-3){1'b0}}, 3'd4};

    // Branch offset: imm is a signed word count, so shift left by two and
    // sign-extend from imm[15] above bit 17.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_br_offset
            if (gi < 2) begin : g_zero
                assign br_offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign br_offset[gi] = bus.imm[gi-2];
            end else begin : g_sign
                assign br_offset[gi] = bus.imm[15];
            end
        end
    endgenerate

    assign br_target   = pc_plus4 + br_offset;
    // Jump keeps the region bits of the already-incremented PC
    assign jump_target = {pc_plus4[WIDTH-1:28], bus.target, 2'b00};
    assign vector      = EXC_BASE + {{(WIDTH-4){1'b0}}, code_reg, 2'b00};

    assign jr_misaligned = bus.pc_write && (bus.pc_sel == SEL_JR) &&
                           (bus.reg_target[1:0] != 2'b00);

    // Branch condition decode from the ALU flags
    always_comb begin
        br_taken = 1'b0;
        case (bus.br_cond)
            2'b00:   br_taken = bus.igual;
            2'b01:   br_taken = !bus.igual;
            2'b10:   br_taken = bus.maior;
            default: br_taken = !bus.maior;
        endcase
    end

    // Next-PC selection; unused select codes fall back to sequential
    always_comb begin
        target_pc = pc_plus4;
        case (bus.pc_sel)
            SEL_SEQ:    target_pc = pc_plus4;
            SEL_BRANCH: target_pc = br_taken ? br_target : pc_plus4;
            SEL_JUMP:   target_pc = jump_target;
            SEL_JR:     target_pc = bus.reg_target;
            SEL_RTE:    target_pc = epc_reg;
            default:    target_pc = pc_plus4;
        endcase
    end

    // Exception state machine and register next values; an exception request
    // beats a simultaneous pc_write so EPC captures the faulting PC.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        code_next  = code_reg;
        ack_next   = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.exc_req) begin
                    code_next  = bus.exc_code;
                    state_next = EXC_SAVE;
                end else if (jr_misaligned) begin
                    code_next  = CODE_ALIGN;
                    state_next = EXC_SAVE;
                end else if (bus.pc_write) begin
                    pc_next = target_pc;
                end
            end
            EXC_SAVE: begin
                epc_next   = pc_reg;
                state_next = EXC_VEC;
            end
            EXC_VEC: begin
                pc_next    = vector;
                ack_next   = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State and datapath registers; reset also discards any pending exception
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= RESET_VECTOR;
            epc_reg   <= '0;
            code_reg  <= 2'd0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            code_reg  <= code_next;
            ack_reg   <= ack_next;
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.epc      = epc_reg;
    assign bus.exc_busy = (state_reg != RUN);
    assign bus.exc_ack  = ack_reg;
endmodule
